// File: rtl/serial_tx_frame_pkg.sv
// Shared definitions for the serial frame transmitter.
//   - tx_state_e  : FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//   - IDLE_LEVEL  : line level while idle and during the stop bit
//   - START_LEVEL : line level during the start bit
//   - even_parity_bit() : parity bit that makes the count of ones even
package serial_tx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Widest data word supported; narrower words are zero-extended.
  localparam int MAX_DATA_W = 16;

  // Zero extension does not change the XOR, so one helper serves every DATA_W.
  function automatic logic even_parity_bit(input logic [MAX_DATA_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_tx_frame_baud_tick_gen.sv
// Bit-period timer for the serial transmitter.
// Ports:
//   clock  : system clock
//   clear  : asynchronous active-high reset
//   enable : counter runs while high, is held at 0 while low
//   tick   : high on the last cycle of each bit period
module baud_tick_gen
  import serial_tx_frame_pkg::*;
#(
  parameter int BAUD_DIV = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  // A 1-bit counter is kept for BAUD_DIV=1 so the vector is never zero width.
  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: hold at zero when disabled, wrap on the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/serial_tx_frame.sv
// Parallel-in, serial-out frame transmitter.
// Frame: start bit (0), DATA_W data bits LSB first, optional even parity bit,
// stop bit (1); every bit lasts BAUD_DIV clocks.
// Ports:
//   clock   : system clock
//   clear   : asynchronous active-high reset
//   start   : send request, sampled only while idle
//   data_in : word captured on the accepting edge
//   tx      : serial line, idles high (registered)
//   busy    : high from the cycle after acceptance through the last stop cycle
//   done    : one-cycle pulse after the stop bit completes
module serial_tx_frame
  import serial_tx_frame_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BAUD_DIV  = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              baud_en_s;
  logic              tick_s;

  assign baud_en_s = (state_q != ST_IDLE);

  baud_tick_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clock  (clock),
    .clear  (clear),
    .enable (baud_en_s),
    .tick   (tick_s)
  );

  // Next-state logic plus output decode from the next state, so that tx/busy
  // change on the same edge as the state and stay registered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d   = data_in;
          parity_d  = even_parity_bit(MAX_DATA_W'(data_in));
          bit_cnt_d = '0;
          state_d   = ST_START;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_IDLE:   tx_d = IDLE_LEVEL;
      ST_START:  tx_d = START_LEVEL;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      ST_STOP:   tx_d = IDLE_LEVEL;
      default:   tx_d = IDLE_LEVEL;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Bench for serial_tx_frame: three instances (8b/div4/parity, 8b/div4/no
// parity, 8b/div1/parity) checked cycle by cycle against a frame model.
module tb_serial_tx_frame;

  logic       clk = 1'b0;
  logic       clear;
  logic       start0, start1, start2;
  logic [7:0] data0, data1, data2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  int checks = 0;
  int passes = 0;
  int cur    = 0;

  logic sel_tx, sel_busy, sel_done;

  always #5 clk = ~clk;

  serial_tx_frame #(.DATA_W(8), .BAUD_DIV(4), .PARITY_EN(1)) dut0 (
    .clock(clk), .clear(clear), .start(start0), .data_in(data0),
    .tx(tx0), .busy(busy0), .done(done0));

  serial_tx_frame #(.DATA_W(8), .BAUD_DIV(4), .PARITY_EN(0)) dut1 (
    .clock(clk), .clear(clear), .start(start1), .data_in(data1),
    .tx(tx1), .busy(busy1), .done(done1));

  serial_tx_frame #(.DATA_W(8), .BAUD_DIV(1), .PARITY_EN(1)) dut2 (
    .clock(clk), .clear(clear), .start(start2), .data_in(data2),
    .tx(tx2), .busy(busy2), .done(done2));

  always_comb begin
    case (cur)
      1:       begin sel_tx = tx1; sel_busy = busy1; sel_done = done1; end
      2:       begin sel_tx = tx2; sel_busy = busy2; sel_done = done2; end
      default: begin sel_tx = tx0; sel_busy = busy0; sel_done = done0; end
    endcase
  end

  function automatic int bd_of(input int sel);
    return (sel == 2) ? 1 : 4;
  endfunction

  function automatic int pen_of(input int sel);
    return (sel == 1) ? 0 : 1;
  endfunction

  // Expected line level for bit slot idx of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int pen, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (pen != 0 && idx == 9) return (($countones(d) % 2) == 1);
    return 1'b1;
  endfunction

  task automatic drive(input int sel, input logic s, input logic [7:0] d);
    case (sel)
      1:       begin start1 = s; data1 = d; end
      2:       begin start2 = s; data2 = d; end
      default: begin start0 = s; data0 = d; end
    endcase
  endtask

  // One-cycle start request; data_in is scrambled right after acceptance.
  task automatic launch(input int sel, input logic [7:0] d);
    @(negedge clk);
    drive(sel, 1'b1, d);
    @(posedge clk);
    #1 drive(sel, 1'b0, ~d);
  endtask

  // Checks every cycle of a frame that was accepted on the last posedge,
  // then the done cycle. Optionally raises start for one cycle at inj_at.
  task automatic check_frame(input int sel, input logic [7:0] d,
                             input int inj_at, input logic [7:0] inj_d);
    int bd;
    int pen;
    int nb;
    logic e;
    bd  = bd_of(sel);
    pen = pen_of(sel);
    nb  = 10 + pen;
    cur = sel;
    for (int k = 0; k < nb * bd; k++) begin
      @(negedge clk);
      e = exp_bit(d, pen, k / bd);
      checks++;
      if (sel_tx !== e)
        $display("FAIL frame_tx dut%0d data=%h cycle %0d: got %b expected %b",
                 sel, d, k, sel_tx, e);
      else passes++;
      checks++;
      if (sel_busy !== 1'b1 || sel_done !== 1'b0)
        $display("FAIL frame_flags dut%0d data=%h cycle %0d: busy=%b done=%b expected busy=1 done=0",
                 sel, d, k, sel_busy, sel_done);
      else passes++;
      if (inj_at >= 0 && k == inj_at) drive(sel, 1'b1, inj_d);
      else if (inj_at >= 0 && k == inj_at + 1) drive(sel, 1'b0, inj_d);
    end
    @(negedge clk);
    checks++;
    if (sel_done !== 1'b1 || sel_busy !== 1'b0 || sel_tx !== 1'b1)
      $display("FAIL done_cycle dut%0d data=%h: done=%b busy=%b tx=%b expected 1,0,1",
               sel, d, sel_done, sel_busy, sel_tx);
    else passes++;
  endtask

  // Cycle after done: pulse must have ended and the line is idle.
  task automatic check_after_done(input int sel);
    cur = sel;
    @(negedge clk);
    checks++;
    if (sel_done !== 1'b0 || sel_busy !== 1'b0 || sel_tx !== 1'b1)
      $display("FAIL after_done dut%0d: done=%b busy=%b tx=%b expected 0,0,1",
               sel, sel_done, sel_busy, sel_tx);
    else passes++;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    drive(0, 1'b1, 8'hFF);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 ||
          tx2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0)
        $display("FAIL reset_hold t=%0t: tx0=%b busy0=%b done0=%b tx2=%b busy2=%b done2=%b expected 1,0,0",
                 $time, tx0, busy0, done0, tx2, busy2, done2);
      else passes++;
    end
    #1;
    drive(0, 1'b0, 8'hFF);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0)
        $display("FAIL reset_idle cycle %0d: tx=%b busy=%b done=%b expected 1,0,0",
                 i, tx0, busy0, done0);
      else passes++;
    end
  endtask

  task automatic test_basic();
    launch(0, 8'hA5);
    check_frame(0, 8'hA5, -1, 8'h00);
    check_after_done(0);
  endtask

  task automatic test_odd_parity();
    launch(0, 8'h07);
    check_frame(0, 8'h07, -1, 8'h00);
    check_after_done(0);
    launch(1, 8'h07);
    check_frame(1, 8'h07, -1, 8'h00);
    check_after_done(1);
  endtask

  task automatic test_start_while_busy();
    launch(0, 8'h5A);
    check_frame(0, 8'h5A, 10, 8'h3C);
    check_after_done(0);
    check_after_done(0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(0, 1'b1, 8'h01);
    @(posedge clk);
    #1 drive(0, 1'b1, 8'h80);
    check_frame(0, 8'h01, -1, 8'h00);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h00);
    check_frame(0, 8'h80, -1, 8'h00);
    check_after_done(0);
  endtask

  task automatic test_midframe_reset();
    logic [7:0] d;
    launch(0, 8'hF0);
    repeat (17) @(negedge clk);
    checks++;
    if (tx0 !== 1'b0 || busy0 !== 1'b1)
      $display("FAIL midreset_pre: tx=%b busy=%b expected 0,1", tx0, busy0);
    else passes++;
    #2 clear = 1'b1;
    #1;
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0)
      $display("FAIL midreset_async: tx=%b busy=%b done=%b expected 1,0,0", tx0, busy0, done0);
    else passes++;
    #4 clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0)
        $display("FAIL midreset_idle cycle %0d: tx=%b busy=%b done=%b expected 1,0,0",
                 i, tx0, busy0, done0);
      else passes++;
    end
    d = 8'($urandom);
    launch(0, d);
    check_frame(0, d, -1, 8'h00);
    check_after_done(0);
  endtask

  task automatic test_random();
    int sel;
    logic [7:0] d;
    for (int n = 0; n < 12; n++) begin
      sel = $urandom_range(0, 2);
      d   = 8'($urandom);
      launch(sel, d);
      check_frame(sel, d, -1, 8'h00);
      check_after_done(sel);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_parity();
    test_start_while_busy();
    test_back_to_back();
    test_midframe_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
